spi_flash_reader: RTL and testbench
===================================

// Module: spi_flash_reader
// PURPOSE
//  SPI master that fetches 64-bit words from the SPI NOR flash over the 03h (READ) command.
//  Sits between the SoC memory/boot path and the flash pins: takes a byte address on a
//  valid/ready request port, runs one CS-framed transaction, returns 8 bytes on a response port.
//  Mode 0 (CPOL=0, CPHA=0), MSB-first, one word per chip-select assertion.
// PARAMETERS
//  CS_NUM    2   number of active-low chip selects driven
//  DIV       2   SCK half-period in clock cycles (>=1); SCK = clock/(2*DIV)
//  CS_IDLE   2   min clock cycles spi_cs stays all-ones between transactions (>=1)
// PORTS
//  clock        in   1        system clock; all state on rising edge
//  reset_n      in   1        asynchronous, active-low reset
//  req_valid    in   1        request present
//  req_ready    out  1        high only in IDLE
//  req_addr     in   24       flash byte address; sent as-is, must be 8-byte aligned
//  req_cs       in   $clog2(CS_NUM)  chip select index
//  resp_valid   out  1        read data available
//  resp_ready   in   1        consumer accepts data
//  resp_data    out  64       resp_data[8*i+7:8*i] = flash byte at req_addr+i
//  spi_clk      out  1        SCK, idles low
//  spi_cs       out  CS_NUM   active-low selects; all-ones when idle
//  spi_mosi     out  1        command/address bits
//  spi_miso     in   1        data from flash
// BEHAVIOUR
//  Reset (async assert, sync deassert not required): state=IDLE, spi_cs='1, spi_clk=0,
//   spi_mosi=0, req_ready=0 until first clock after release, resp_valid=0, resp_data=0.
//  FSM: IDLE -> SETUP -> SHIFT -> HOLD -> RESP -> GAP -> IDLE.
//  IDLE: req_ready=1; req_valid&req_ready latches addr/cs, shreg_out={8'h03,req_addr}.
//  SETUP: spi_cs[req_cs]=0, SCK low, mosi=bit 31 of shreg_out; lasts DIV cycles.
//  SHIFT: 96 SCK periods (8 cmd + 24 addr + 64 data); counter 0..95.
//   Each period: DIV cycles low then DIV cycles high. mosi changes only at the SCK falling
//   edge (period start); during periods 32..95 mosi=0.
//   miso sampled on the clock edge that drives SCK 0->1 (value held during the low phase),
//   for periods 32..95 only, into shreg_in MSB-first.
//  HOLD: SCK low for DIV cycles, CS still asserted; then spi_cs='1.
//  RESP: resp_data = byte-swap(shreg_in): first received byte -> [7:0]; resp_valid=1 held,
//   resp_data stable, until resp_valid&resp_ready; no new request accepted meanwhile.
//  GAP: CS_IDLE cycles with spi_cs='1, then IDLE (flash model resets its FSM on CS high).
//  Latency req accept -> resp_valid: DIV + 96*2*DIV + DIV + 1 cycles.
//  Boundaries: counter 95 -> HOLD, no wrap; req_valid during busy ignored (req_ready=0);
//   resp_ready high before resp_valid has no effect; reset_n low mid-SHIFT drops CS and SCK
//   the same instant, aborted word is discarded, no resp_valid.
//  Out-of-range req_cs: no CS asserted, transaction still runs, resp_data = sampled miso.
// STRUCTURE
//  spi_pkg: state_t enum {IDLE,SETUP,SHIFT,HOLD,RESP,GAP}, FLASH_CMD_READ=8'h03,
//   CMD_BITS=8, ADDR_BITS=24, DATA_BITS=64, XFER_BITS=96.
//  Sub-module spi_sck_div: half-period counter, outputs rise/fall strobes and spi_clk,
//   enabled only in SHIFT; top keeps FSM, bit counter and shift registers.
// TESTING
//  Bench instantiates this block with the flash sim model on cs[0] and preloaded image.
//  1 Image bytes 00..07 = 11 22 33 44 55 66 77 88, req_addr=0 -> resp_data=64'h8877665544332211.
//  2 req_addr=24'h000008, DIV=1 -> resp_data = bytes 8..15; latency exactly 195 cycles.
//  3 Back-to-back: req_valid held for addr 0 then 8 -> two responses in order; spi_cs='1 for
//    >=CS_IDLE cycles between; mosi first 8 bits each frame = 00000011.
//  4 resp_ready low 20 cycles -> resp_valid, resp_data stable; req_ready=0 throughout.
//  5 reset_n low at SHIFT counter 40 -> spi_cs='1, spi_clk=0 same cycle; next req addr 0
//    returns 64'h8877665544332211 (flash model resynchronised).
//  6 DIV=3: SCK high/low exactly 3 cycles each; mosi toggles only at SCK falling edges.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI NOR flash READ (03h) master.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    RESP,
    GAP
  } state_t;

  localparam logic [7:0] FLASH_CMD_READ = 8'h03;
  localparam int CMD_BITS  = 8;
  localparam int ADDR_BITS = 24;
  localparam int DATA_BITS = 64;
  localparam int XFER_BITS = 96;
  localparam int HDR_BITS  = CMD_BITS + ADDR_BITS;

  // The first byte off the wire lands in the MSBs of the shift register;
  // the response wants it in the LSBs (little-endian word).
  function automatic logic [DATA_BITS-1:0] byte_swap64(input logic [DATA_BITS-1:0] d);
    logic [DATA_BITS-1:0] r;
    r = '0;
    for (int i = 0; i < DATA_BITS / 8; i++) begin
      r[8*i +: 8] = d[DATA_BITS-1-8*i -: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/spi_sck_div.sv
// SCK generator: DIV cycles low then DIV cycles high per period, idles low
// whenever disabled. The strobes mark the clock edge that flips SCK.
module spi_sck_div #(
  parameter int DIV = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic en,
  output logic spi_clk,
  output logic sck_rise,
  output logic sck_fall
);

  localparam int HCW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [HCW-1:0] half_cnt;
  logic           half_end;

  assign half_end = (half_cnt == HCW'(DIV - 1));
  assign sck_rise = en && !spi_clk && half_end;
  assign sck_fall = en &&  spi_clk && half_end;

  // Half-period counter; SCK toggles at the end of each half period.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      half_cnt <= '0;
      spi_clk  <= 1'b0;
    end else if (!en) begin
      half_cnt <= '0;
      spi_clk  <= 1'b0;
    end else if (half_end) begin
      half_cnt <= '0;
      spi_clk  <= ~spi_clk;
    end else begin
      half_cnt <= half_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_flash_reader.sv
// SPI mode-0 master fetching one 64-bit little-endian word per chip-select
// frame with the flash READ (03h) command: 8 cmd + 24 addr bits out, 64 in.
module spi_flash_reader
  import spi_pkg::*;
#(
  parameter int CS_NUM  = 2,
  parameter int DIV     = 2,
  parameter int CS_IDLE = 2
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [ADDR_BITS-1:0]      req_addr,
  input  logic [$clog2(CS_NUM)-1:0] req_cs,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [DATA_BITS-1:0]      resp_data,
  output logic                      spi_clk,
  output logic [CS_NUM-1:0]         spi_cs,
  output logic                      spi_mosi,
  input  logic                      spi_miso
);

  localparam int WCW = 16;

  state_t                    state, state_nx;
  logic                      alive;
  logic [WCW-1:0]            wait_cnt;
  logic [6:0]                bit_cnt;
  logic [HDR_BITS-1:0]       shreg_out;
  logic [DATA_BITS-1:0]      shreg_in;
  logic [$clog2(CS_NUM)-1:0] cs_q;
  logic                      div_en, sck_rise, sck_fall;
  logic                      div_done, gap_done, accept;

  assign div_done = (wait_cnt == WCW'(DIV - 1));
  assign gap_done = (wait_cnt == WCW'(CS_IDLE - 1));
  assign accept   = req_valid && req_ready;

  spi_sck_div #(.DIV(DIV)) u_sck_div (
    .clock    (clock),
    .reset_n  (reset_n),
    .en       (div_en),
    .spi_clk  (spi_clk),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall)
  );

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state logic: one frame per request, then a CS-high gap.
  // NOTE: the default assignment up front covers every path, so no latch is inferred.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = SETUP;
      SETUP:   if (div_done) state_nx = SHIFT;
      SHIFT:   if (sck_fall && bit_cnt == 7'(XFER_BITS - 1)) state_nx = HOLD;
      HOLD:    if (div_done) state_nx = RESP;
      RESP:    if (resp_valid && resp_ready) state_nx = GAP;
      GAP:     if (gap_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Pin and handshake outputs decoded from state; CS drops with state on reset.
  always_comb begin
    req_ready = (state == IDLE) && alive;
    div_en    = (state == SHIFT);
    spi_cs    = '1;
    if (state inside {SETUP, SHIFT, HOLD}) begin
      for (int i = 0; i < CS_NUM; i++) begin
        if (int'(cs_q) == i) spi_cs[i] = 1'b0;
      end
    end
    spi_mosi = 1'b0;
    if (state == SETUP || (state == SHIFT && bit_cnt < 7'(HDR_BITS))) begin
      spi_mosi = shreg_out[HDR_BITS-1];
    end
  end

  // Datapath: phase timer, bit counter, shift registers, response register.
  // NOTE: the shift registers are plain flops, not a RAM, so they take the
  // async reset like everything else and mosi/resp_data come up defined.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      alive      <= 1'b0;
      wait_cnt   <= '0;
      bit_cnt    <= '0;
      shreg_out  <= '0;
      shreg_in   <= '0;
      cs_q       <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
    end else begin
      alive <= 1'b1;

      if (state_nx != state)                 wait_cnt <= '0;
      else if (state inside {SETUP, HOLD, GAP}) wait_cnt <= wait_cnt + 1'b1;

      if (state == IDLE && accept) begin
        shreg_out <= {FLASH_CMD_READ, req_addr};
        cs_q      <= req_cs;
        bit_cnt   <= '0;
      end else if (sck_fall) begin
        shreg_out <= shreg_out << 1;
        bit_cnt   <= bit_cnt + 1'b1;
      end

      // Data phase only: sample on the edge that raises SCK.
      if (sck_rise && bit_cnt >= 7'(HDR_BITS)) begin
        shreg_in <= {shreg_in[DATA_BITS-2:0], spi_miso};
      end

      if (state == RESP && !resp_valid) begin
        resp_valid <= 1'b1;
        resp_data  <= byte_swap64(shreg_in);
      end else if (resp_valid && resp_ready) begin
        resp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench: two readers (DIV=1 and DIV=3), each with a behavioural SPI NOR flash
// on cs[0] backed by a shared 256-byte image; random aligned reads are
// compared against words assembled straight from the image.
module tb_spi_flash_reader;

  localparam int CS_IDLE = 2;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid[2], req_ready[2], resp_valid[2], resp_ready[2];
  logic        spi_clk[2], spi_mosi[2], spi_miso[2];
  logic [0:0]  req_cs[2];
  logic [23:0] req_addr[2];
  logic [63:0] resp_data[2];
  logic [1:0]  spi_cs[2];
  logic [7:0]  img[256];

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int hi_min[2] = '{1000, 1000};
  int hi_max[2] = '{0, 0};
  int lo_min[2] = '{1000, 1000};
  int lo_max[2] = '{0, 0};
  int mosi_bad[2] = '{0, 0};
  int min_gap[2] = '{1000, 1000};
  int cmd_ok[2] = '{0, 0};
  logic [1:0] cs_seen[2] = '{2'b11, 2'b11};

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  spi_flash_reader #(.CS_NUM(2), .DIV(1), .CS_IDLE(CS_IDLE)) u_dut0 (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr[0]), .req_cs(req_cs[0]), .resp_valid(resp_valid[0]),
    .resp_ready(resp_ready[0]), .resp_data(resp_data[0]), .spi_clk(spi_clk[0]),
    .spi_cs(spi_cs[0]), .spi_mosi(spi_mosi[0]), .spi_miso(spi_miso[0])
  );

  spi_flash_reader #(.CS_NUM(2), .DIV(3), .CS_IDLE(CS_IDLE)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr[1]), .req_cs(req_cs[1]), .resp_valid(resp_valid[1]),
    .resp_ready(resp_ready[1]), .resp_data(resp_data[1]), .spi_clk(spi_clk[1]),
    .spi_cs(spi_cs[1]), .spi_mosi(spi_mosi[1]), .spi_miso(spi_miso[1])
  );

  for (genvar g = 0; g < 2; g++) begin : g_flash
    int          n = 0;
    logic [31:0] hdr = '0;
    logic        fl_out = 1'b0;

    // Deselected flash leaves the line pulled high.
    assign spi_miso[g] = spi_cs[g][0] ? 1'b1 : fl_out;

    // Command/address capture on SCK rise; CS high resets the flash.
    always @(posedge spi_clk[g] or posedge spi_cs[g][0]) begin
      if (spi_cs[g][0]) begin
        n = 0;
      end else begin
        if (n < 32) hdr = {hdr[30:0], spi_mosi[g]};
        n++;
        if (n == 8 && hdr[7:0] == 8'h03) cmd_ok[g]++;
      end
    end

    // Data bit k driven after the SCK fall that follows the 32nd rise.
    always @(negedge spi_clk[g]) begin : drive
      int         k;
      logic [7:0] b;
      if (!spi_cs[g][0] && n >= 32 && n < 96) begin
        k = n - 32;
        b = (hdr[31:24] == 8'h03) ? img[8'(hdr[7:0] + 8'(k / 8))] : 8'h00;
        fl_out = b[7 - (k % 8)];
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_mon
    logic prev_sck = 1'b0;
    logic prev_mosi = 1'b0;
    bit   from_fall = 1'b0;
    bit   seen = 1'b0;
    int   run = 0;
    int   idle_run = 0;

    // SCK phase lengths inside a frame, mosi edge alignment, CS gaps.
    always @(negedge clock) begin
      if (spi_clk[g] !== prev_sck) begin
        if (prev_sck) begin
          if (run < hi_min[g]) hi_min[g] = run;
          if (run > hi_max[g]) hi_max[g] = run;
        end else if (from_fall) begin
          if (run < lo_min[g]) lo_min[g] = run;
          if (run > lo_max[g]) lo_max[g] = run;
        end
        from_fall = prev_sck;
        run = 1;
      end else begin
        run++;
      end
      if (spi_mosi[g] !== prev_mosi && !(prev_sck && !spi_clk[g])) mosi_bad[g]++;
      if (spi_cs[g] != 2'b11) begin
        cs_seen[g] = spi_cs[g];
        if (seen && idle_run > 0 && idle_run < min_gap[g]) min_gap[g] = idle_run;
        idle_run = 0;
        seen = 1'b1;
      end else begin
        idle_run++;
        from_fall = 1'b0;
      end
      prev_sck = spi_clk[g];
      prev_mosi = spi_mosi[g];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_word(input logic [23:0] a);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = img[(int'(a[7:0]) + i) % 256];
    return r;
  endfunction

  // One request/response; resp_ready held high from the start.
  task automatic do_read(input int u, input logic [23:0] a, input logic c,
                         output logic [63:0] d, output int lat);
    int t0;
    int guard;
    @(negedge clock);
    req_valid[u] = 1'b1;
    req_addr[u] = a;
    req_cs[u] = c;
    resp_ready[u] = 1'b1;
    guard = 0;
    while (!req_ready[u] && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    @(posedge clock);
    @(negedge clock);
    t0 = cyc;
    req_valid[u] = 1'b0;
    guard = 0;
    while (!resp_valid[u] && guard < 5000) begin
      @(negedge clock);
      guard++;
    end
    lat = cyc - t0;
    d = resp_data[u];
    @(negedge clock);
  endtask

  initial begin
    logic [63:0] d;
    logic [63:0] d0;
    logic [23:0] a;
    int lat, guard, ok, c0;

    for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) img[i] = 8'(8'h11 * (i + 1));
    for (int u = 0; u < 2; u++) begin
      req_valid[u] = 1'b0;
      req_addr[u] = '0;
      req_cs[u] = '0;
      resp_ready[u] = 1'b0;
    end

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_cs", 64'(spi_cs[0]), 64'h3);
    check("rst_sck", 64'(spi_clk[0]), 64'h0);
    check("rst_mosi", 64'(spi_mosi[0]), 64'h0);
    check("rst_ready", 64'(req_ready[0]), 64'h0);
    check("rst_rvalid", 64'(resp_valid[0]), 64'h0);
    check("rst_rdata", resp_data[0], 64'h0);
    reset_n = 1'b1;
    #1;
    check("ready_pre_clk", 64'(req_ready[0]), 64'h0);
    @(negedge clock);
    check("ready_post_clk", 64'(req_ready[0]), 64'h1);

    // Known image bytes, then next aligned word with exact latency
    do_read(0, 24'h0, 1'b0, d, lat);
    check("word0", d, 64'h8877665544332211);
    check("lat0", 64'(lat), 64'd195);
    check("cs_sel0", 64'(cs_seen[0]), 64'h2);
    do_read(0, 24'h8, 1'b0, d, lat);
    check("word8", d, exp_word(24'h8));
    check("lat8", 64'(lat), 64'd195);

    // Random aligned addresses
    for (int i = 0; i < 6; i++) begin
      a = 24'($urandom_range(0, 31)) << 3;
      do_read(0, a, 1'b0, d, lat);
      check("rand_word", d, exp_word(a));
      check("rand_lat", 64'(lat), 64'd195);
    end

    // Other chip select: flash stays deselected, data is the idle-high line
    do_read(0, 24'h10, 1'b1, d, lat);
    check("cs_sel1", 64'(cs_seen[0]), 64'h1);
    check("cs1_data", d, 64'hFFFF_FFFF_FFFF_FFFF);

    // Back-to-back with req_valid held
    c0 = cmd_ok[0];
    @(negedge clock);
    req_addr[0] = 24'h0;
    req_cs[0] = 1'b0;
    req_valid[0] = 1'b1;
    resp_ready[0] = 1'b1;
    guard = 0;
    while (!req_ready[0] && guard < 200) begin @(negedge clock); guard++; end
    @(posedge clock);
    @(negedge clock);
    req_addr[0] = 24'h8;
    guard = 0;
    while (!resp_valid[0] && guard < 5000) begin @(negedge clock); guard++; end
    check("b2b_first", resp_data[0], 64'h8877665544332211);
    @(negedge clock);
    guard = 0;
    while (!req_ready[0] && guard < 200) begin @(negedge clock); guard++; end
    @(posedge clock);
    @(negedge clock);
    req_valid[0] = 1'b0;
    guard = 0;
    while (!resp_valid[0] && guard < 5000) begin @(negedge clock); guard++; end
    check("b2b_second", resp_data[0], exp_word(24'h8));
    @(negedge clock);
    check("b2b_cmds", 64'(cmd_ok[0] - c0), 64'd2);
    check("cs_gap_ok", 64'(min_gap[0] >= CS_IDLE), 64'h1);

    // Consumer stall for 20 cycles with a competing request pending
    a = 24'($urandom_range(0, 31)) << 3;
    @(negedge clock);
    req_addr[0] = a;
    req_valid[0] = 1'b1;
    resp_ready[0] = 1'b0;
    guard = 0;
    while (!req_ready[0] && guard < 200) begin @(negedge clock); guard++; end
    @(posedge clock);
    @(negedge clock);
    req_addr[0] = 24'hF0;
    guard = 0;
    while (!resp_valid[0] && guard < 5000) begin @(negedge clock); guard++; end
    d0 = resp_data[0];
    ok = 1;
    repeat (20) begin
      @(negedge clock);
      if (!(resp_valid[0] && resp_data[0] == d0 && !req_ready[0])) ok = 0;
    end
    check("stall_data", d0, exp_word(a));
    check("stall_stable", 64'(ok), 64'h1);
    resp_ready[0] = 1'b1;
    @(negedge clock);
    req_valid[0] = 1'b0;
    resp_ready[0] = 1'b0;
    check("stall_release", 64'(resp_valid[0]), 64'h0);
    repeat (10) @(negedge clock);
    check("busy_req_ignored", 64'(resp_valid[0]), 64'h0);

    // Reset in the data phase (around SHIFT period 40)
    @(negedge clock);
    req_addr[0] = 24'h18;
    req_valid[0] = 1'b1;
    resp_ready[0] = 1'b1;
    guard = 0;
    while (!req_ready[0] && guard < 200) begin @(negedge clock); guard++; end
    @(posedge clock);
    @(negedge clock);
    req_valid[0] = 1'b0;
    repeat (81) @(negedge clock);
    check("mid_frame_cs", 64'(spi_cs[0]), 64'h2);
    reset_n = 1'b0;
    #1;
    check("abort_cs", 64'(spi_cs[0]), 64'h3);
    check("abort_sck", 64'(spi_clk[0]), 64'h0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (300) @(negedge clock);
    check("abort_no_resp", 64'(resp_valid[0]), 64'h0);
    do_read(0, 24'h0, 1'b0, d, lat);
    check("resync_word0", d, 64'h8877665544332211);

    // Slow SCK instance
    c0 = cmd_ok[1];
    for (int i = 0; i < 2; i++) begin
      a = 24'($urandom_range(0, 31)) << 3;
      do_read(1, a, 1'b0, d, lat);
      check("div3_word", d, exp_word(a));
      check("div3_lat", 64'(lat), 64'd583);
    end
    check("div3_cmds", 64'(cmd_ok[1] - c0), 64'd2);
    check("div3_hi_min", 64'(hi_min[1]), 64'd3);
    check("div3_hi_max", 64'(hi_max[1]), 64'd3);
    check("div3_lo_min", 64'(lo_min[1]), 64'd3);
    check("div3_lo_max", 64'(lo_max[1]), 64'd3);
    check("div3_mosi_edges", 64'(mosi_bad[1]), 64'd0);
    check("div1_mosi_edges", 64'(mosi_bad[0]), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
